// File: rtl/lut_eval.sv
// lut_eval: run-time programmable N_IN-input / N_OUT-output truth table.
// The table is streamed in row by row, then either evaluated one vector
// per cycle or replayed exhaustively (sweep) for comparison against
// hand-reduced expressions.
module lut_eval #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             cfg_restart,
  output logic             loaded,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  output logic [N_OUT-1:0] out_vec,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic [N_IN-1:0]  sweep_idx,
  output logic             sweep_done
);

  localparam int              DEPTH = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST  = '1;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_SWEEP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Table contents carry no reset: a restart or reset always forces a full reload.
  logic [N_OUT-1:0] r_table [DEPTH];
  logic [N_IN-1:0]  r_ptr;
  logic [N_IN-1:0]  r_cnt;

  logic w_cfg_fire;
  logic w_eval;
  logic w_sweep_go;
  logic w_sweep_row;
  logic w_sweep_last;

  // cfg_restart dominates every other qualifier; sweep_start beats in_valid in RUN.
  assign w_cfg_fire   = cfg_valid & cfg_ready & ~cfg_restart;
  assign w_eval       = (r_state == S_RUN) & in_valid & ~sweep_start & ~cfg_restart;
  assign w_sweep_go   = (r_state == S_RUN) & sweep_start & ~cfg_restart;
  assign w_sweep_row  = (r_state == S_SWEEP) & ~cfg_restart;
  assign w_sweep_last = w_sweep_row & (r_cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    if (cfg_restart) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_cfg_fire && (r_ptr == LAST)) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (sweep_start) begin
            w_state_nxt = S_SWEEP;
          end
        end
        S_SWEEP: begin
          if (r_cnt == LAST) begin
            w_state_nxt = S_RUN;
          end
        end
        default: w_state_nxt = S_LOAD;
      endcase
    end
  end

  // State-decoded status outputs
  always_comb begin
    cfg_ready  = (r_state == S_LOAD);
    loaded     = (r_state == S_RUN) || (r_state == S_SWEEP);
    sweep_busy = (r_state == S_SWEEP);
  end

  // Load pointer: advances on each accepted beat, wraps to 0 after the last row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (cfg_restart) begin
      r_ptr <= '0;
    end else if (w_cfg_fire) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  // Sweep row counter: cleared on sweep entry, advances every sweep cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cfg_restart || w_sweep_go) begin
      r_cnt <= '0;
    end else if (w_sweep_row) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Table write port
  always_ff @(posedge clk) begin
    if (w_cfg_fire) begin
      r_table[r_ptr] <= cfg_data;
    end
  end

  // Result valid: one cycle after an eval, and on every sweep row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= w_eval | w_sweep_row;
    end
  end

  // Result data: holds its last value when nothing is produced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vec <= '0;
    end else if (w_eval) begin
      out_vec <= r_table[in_vec];
    end else if (w_sweep_row) begin
      out_vec <= r_table[r_cnt];
    end
  end

  // Sweep row index, aligned with out_vec
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_idx <= '0;
    end else if (w_sweep_row) begin
      sweep_idx <= r_cnt;
    end
  end

  // Last-row marker, a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= w_sweep_last;
    end
  end

endmodule

// File: tb/tb_lut_eval.sv
// Directed bench for lut_eval with N_IN=3, N_OUT=2.
module tb_lut_eval;

  localparam int N_IN  = 3;
  localparam int N_OUT = 2;

  logic             clk;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [N_OUT-1:0] cfg_data;
  logic             cfg_restart;
  logic             loaded;
  logic             in_valid;
  logic [N_IN-1:0]  in_vec;
  logic             out_valid;
  logic [N_OUT-1:0] out_vec;
  logic             sweep_start;
  logic             sweep_busy;
  logic [N_IN-1:0]  sweep_idx;
  logic             sweep_done;

  int n_chk;
  int n_fail;

  int rows_a [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
  int rows_b [8] = '{3, 2, 1, 0, 0, 1, 2, 3};
  int ev_in  [4] = '{5, 0, 7, 3};
  int ev_exp [4] = '{2, 0, 0, 3};

  lut_eval #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_restart(cfg_restart),
    .loaded     (loaded),
    .in_valid   (in_valid),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_vec    (out_vec),
    .sweep_start(sweep_start),
    .sweep_busy (sweep_busy),
    .sweep_idx  (sweep_idx),
    .sweep_done (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".cfg_ready"},  int'(cfg_ready),  1);
    chk({tag, ".loaded"},     int'(loaded),     0);
    chk({tag, ".out_valid"},  int'(out_valid),  0);
    chk({tag, ".out_vec"},    int'(out_vec),    0);
    chk({tag, ".sweep_busy"}, int'(sweep_busy), 0);
    chk({tag, ".sweep_idx"},  int'(sweep_idx),  0);
    chk({tag, ".sweep_done"}, int'(sweep_done), 0);
  endtask

  // Runs sweep rows 0..last_k after sweep_start was sampled, with rows_a contents.
  task automatic sweep_rows(input string tag, input int last_k);
    for (int k = 0; k <= last_k; k++) begin
      tick();
      chk({tag, ".valid"}, int'(out_valid),  1);
      chk({tag, ".idx"},   int'(sweep_idx),  k);
      chk({tag, ".row"},   int'(out_vec),    rows_a[k]);
      chk({tag, ".done"},  int'(sweep_done), (k == 7) ? 1 : 0);
      chk({tag, ".busy"},  int'(sweep_busy), (k == 7) ? 0 : 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_data    = '0;
    cfg_restart = 1'b0;
    in_valid    = 1'b0;
    in_vec      = '0;
    sweep_start = 1'b0;

    #2;
    chk_reset_vals("rst");
    tick();
    tick();
    rst_n = 1'b1;

    // Load rows 0..7 back to back
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = N_OUT'(rows_a[i]);
      chk("load.ready", int'(cfg_ready), 1);
      chk("load.loaded_pre", int'(loaded), 0);
      tick();
    end
    chk("load.loaded", int'(loaded), 1);
    chk("load.ready_off", int'(cfg_ready), 0);
    // Beats while not ready must be dropped
    cfg_data = 2'd3;
    tick();
    tick();
    cfg_valid = 1'b0;

    // Evaluate stream, one vector per cycle
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_vec   = N_IN'(ev_in[i]);
      tick();
      chk("eval.valid", int'(out_valid), 1);
      chk("eval.data", int'(out_vec), ev_exp[i]);
    end
    in_valid = 1'b0;
    tick();
    chk("eval.idle_valid", int'(out_valid), 0);
    chk("eval.hold", int'(out_vec), 3);

    // Exhaustive sweep with in_valid held throughout
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    in_valid    = 1'b1;
    in_vec      = 3'd6;
    chk("sw1.busy0", int'(sweep_busy), 1);
    chk("sw1.valid0", int'(out_valid), 0);
    sweep_rows("sw1", 7);
    in_valid = 1'b0;
    tick();
    chk("sw1.after_valid", int'(out_valid), 0);
    chk("sw1.after_done", int'(sweep_done), 0);

    // sweep_start wins over a simultaneous in_valid
    sweep_start = 1'b1;
    in_valid    = 1'b1;
    in_vec      = 3'd1;
    tick();
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    chk("prio.no_eval", int'(out_valid), 0);
    chk("prio.busy", int'(sweep_busy), 1);
    sweep_rows("sw2", 7);
    tick();

    // Restart while sweep_idx=4
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    sweep_rows("sw3", 4);
    cfg_restart = 1'b1;
    tick();
    cfg_restart = 1'b0;
    chk("rs.valid", int'(out_valid), 0);
    chk("rs.busy", int'(sweep_busy), 0);
    chk("rs.done", int'(sweep_done), 0);
    chk("rs.loaded", int'(loaded), 0);
    chk("rs.ready", int'(cfg_ready), 1);
    tick();
    chk("rs.no_done_late", int'(sweep_done), 0);
    chk("rs.no_valid_late", int'(out_valid), 0);

    // Reload rows 7..0 reversed
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = N_OUT'(rows_a[7 - i]);
      tick();
    end
    cfg_valid = 1'b0;
    chk("reload.loaded", int'(loaded), 1);
    in_valid = 1'b1;
    in_vec   = 3'd0;
    tick();
    chk("reload.r0", int'(out_vec), 0);
    in_vec = 3'd1;
    tick();
    chk("reload.r1", int'(out_vec), 1);
    in_valid = 1'b0;
    tick();

    // Async reset mid-load after 3 beats
    cfg_restart = 1'b1;
    tick();
    cfg_restart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 2'd2;
      tick();
    end
    cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    #1;
    rst_n = 1'b1;

    // Full 8-beat load needed again; row 0 must land at address 0
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = N_OUT'(rows_b[i]);
      tick();
      if (i == 6) chk("arst.loaded_7", int'(loaded), 0);
    end
    cfg_valid = 1'b0;
    chk("arst.loaded_8", int'(loaded), 1);
    in_valid = 1'b1;
    in_vec   = 3'd0;
    tick();
    chk("arst.r0", int'(out_vec), 3);
    in_vec = 3'd5;
    tick();
    chk("arst.r5", int'(out_vec), 1);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
